// File: rtl/MD_pkg.sv
// MD_pkg: shared number-format defaults for the fixed-point to float converter.
package MD_pkg;

  localparam int MD_DATA_WIDTH     = 32;
  localparam int MD_CELL_ID_WIDTH  = 2;
  localparam int MD_EXP_WIDTH      = 8;
  localparam int MD_MANTISSA_WIDTH = 23;
  localparam int MD_EXP_BIAS       = 127;
  localparam int MD_FLOAT_WIDTH    = 1 + MD_EXP_WIDTH + MD_MANTISSA_WIDTH;

endpackage

// File: rtl/lzc.sv
// lzc: combinational leading-zero counter. o_count = WIDTH when the input is zero.
module lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           i_data,
  output logic [$clog2(WIDTH+1)-1:0] o_count,
  output logic                       o_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Scan LSB to MSB so the highest set bit is the last one to write the count
  always_comb begin
    o_count = CNT_W'(WIDTH);
    o_zero  = ~|i_data;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = i_data[i] ? CNT_W'(WIDTH - 1 - i) : o_count;
    end
  end

endmodule

// File: rtl/fixed2float_pipe.sv
// fixed2float_pipe: NUM_CH-lane unsigned fixed-point to float converter,
// 2-stage valid/ready pipeline (S1 = leading-one detect + normalise,
// S2 = round/truncate, exponent assembly, output register).
// Build option: define FIX2FLT_ROUND_EN for round-to-nearest-even mantissa;
// without it the discarded bits are truncated. Latency is the same either way.
module fixed2float_pipe
  import MD_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = MD_DATA_WIDTH,
  parameter int CELL_ID_WIDTH  = MD_CELL_ID_WIDTH,
  parameter int EXP_WIDTH      = MD_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = MD_MANTISSA_WIDTH,
  parameter int EXP_BIAS       = MD_EXP_BIAS,
  parameter int FLOAT_WIDTH    = MD_FLOAT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*FLOAT_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]             out_zero
);

  localparam int FRAC     = DATA_WIDTH - CELL_ID_WIDTH;
  localparam int LZ_W     = $clog2(DATA_WIDTH + 1);
  // exponent = EXP_BIAS + p - FRAC with p = DATA_WIDTH-1-lz
  localparam int EXP_BASE = EXP_BIAS - FRAC + DATA_WIDTH - 1;

  // S1 combinational lane results
  logic [LZ_W-1:0]         w_lz   [NUM_CH];
  logic                    w_zero [NUM_CH];
  logic [DATA_WIDTH-2:0]   w_frac [NUM_CH];

  // S1 registers
  logic                    r_s1_valid;
  logic [LZ_W-1:0]         r_s1_lz   [NUM_CH];
  logic [DATA_WIDTH-2:0]   r_s1_frac [NUM_CH];
  logic                    r_s1_zero [NUM_CH];

  // S2 combinational lane results
  logic [EXP_WIDTH-1:0]      w_exp  [NUM_CH];
  logic [MANTISSA_WIDTH-1:0] w_mant [NUM_CH];
`ifdef FIX2FLT_ROUND_EN
  localparam logic [DATA_WIDTH-2:0] STICKY_MASK = (DATA_WIDTH - 2 > MANTISSA_WIDTH) ?
      (DATA_WIDTH-1)'((64'd1 << (DATA_WIDTH - 2 - MANTISSA_WIDTH)) - 64'd1) :
      {(DATA_WIDTH-1){1'b0}};
  logic [MANTISSA_WIDTH-1:0] w_mant_trunc [NUM_CH];
  logic                      w_guard      [NUM_CH];
  logic                      w_sticky     [NUM_CH];
  logic [MANTISSA_WIDTH:0]   w_mant_rnd   [NUM_CH];
`endif

  // Output registers
  logic                          r_out_valid;
  logic [NUM_CH*FLOAT_WIDTH-1:0] r_out_data;
  logic [NUM_CH-1:0]             r_out_zero;

  logic w_s2_can_accept;

  assign w_s2_can_accept = !r_out_valid || out_ready;
  assign in_ready        = !r_s1_valid || w_s2_can_accept;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_zero        = r_out_zero;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    lzc #(.WIDTH(DATA_WIDTH)) u_lzc (
      .i_data  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_count (w_lz[g]),
      .o_zero  (w_zero[g])
    );
    // Normalise so the leading one sits at the MSB, then drop it (implicit bit)
    assign w_frac[g] = (DATA_WIDTH-1)'(in_data[g*DATA_WIDTH +: DATA_WIDTH] << w_lz[g]);
  end

  // S1 register: capture the normalised lanes whenever the stage can advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_s1_lz[i]   <= {LZ_W{1'b0}};
        r_s1_frac[i] <= {(DATA_WIDTH-1){1'b0}};
        r_s1_zero[i] <= 1'b0;
      end
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_s1_lz[i]   <= w_lz[i];
          r_s1_frac[i] <= w_frac[i];
          r_s1_zero[i] <= w_zero[i];
        end
      end
    end
  end

  // S2 datapath: exponent from the shift count, mantissa truncated or rounded
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_exp[i] = EXP_WIDTH'(EXP_BASE - int'(r_s1_lz[i]));
`ifdef FIX2FLT_ROUND_EN
      {w_mant_trunc[i], w_guard[i]} = (MANTISSA_WIDTH+1)'(
          {r_s1_frac[i], {(MANTISSA_WIDTH+1){1'b0}}} >> (DATA_WIDTH - 1));
      w_sticky[i]   = |(r_s1_frac[i] & STICKY_MASK);
      w_mant_rnd[i] = {1'b0, w_mant_trunc[i]} +
          {{MANTISSA_WIDTH{1'b0}}, w_guard[i] & (w_sticky[i] | w_mant_trunc[i][0])};
      if (w_mant_rnd[i][MANTISSA_WIDTH]) begin
        // all-ones mantissa rounded up: renormalise into the next binade
        w_mant[i] = {MANTISSA_WIDTH{1'b0}};
        w_exp[i]  = w_exp[i] + {{(EXP_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        w_mant[i] = w_mant_rnd[i][MANTISSA_WIDTH-1:0];
      end
`else
      w_mant[i] = MANTISSA_WIDTH'({r_s1_frac[i], {MANTISSA_WIDTH{1'b0}}} >> (DATA_WIDTH - 1));
`endif
    end
  end

  // S2 output register: load from S1 when downstream has room, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {(NUM_CH*FLOAT_WIDTH){1'b0}};
      r_out_zero  <= {NUM_CH{1'b0}};
    end else if (w_s2_can_accept) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_out_data[i*FLOAT_WIDTH +: FLOAT_WIDTH] <= r_s1_zero[i] ?
              {FLOAT_WIDTH{1'b0}} : {1'b0, w_exp[i], w_mant[i]};
          r_out_zero[i] <= r_s1_zero[i];
        end
      end
    end
  end

endmodule
